control_sequencer: RTL

- Microcoded control unit for the 8-bit bus computer.
- Runs a T-state step counter and decodes the opcode held in the instruction register.
- Drives every load/enable strobe on the shared bus, including pc_inc / pc_load / pc_out to the program counter directly downstream.
- Each instruction executes as a fetch (T0-T1) followed by execute steps (T2-T4).

---
 rtl/control_sequencer_if.sv | 42 ++++
 rtl/control_sequencer.sv | 206 ++++++++++++++++++++
 2 files changed

// File: rtl/control_sequencer_if.sv
// Bus-side signal group for the control sequencer.
// The master modport belongs to the sequencer. It reads the instruction
// register and the flags, and it drives the step index and every strobe.
// The slave modport is the view seen by the datapath blocks that sit on the bus.
interface control_sequencer_if #(
    parameter int STEP_W = 3
);
    logic [7:0]        instr;
    logic              flag_c;
    logic              flag_z;
    logic [STEP_W-1:0] step;
    logic              hlt;
    logic              mar_in;
    logic              ram_in;
    logic              ram_out;
    logic              ir_in;
    logic              ir_out;
    logic              a_in;
    logic              a_out;
    logic              b_in;
    logic              alu_out;
    logic              alu_sub;
    logic              flags_in;
    logic              out_in;
    logic              pc_inc;
    logic              pc_load;
    logic              pc_out;

    modport master (
        input  instr, flag_c, flag_z,
        output step, hlt, mar_in, ram_in, ram_out, ir_in, ir_out,
               a_in, a_out, b_in, alu_out, alu_sub, flags_in, out_in,
               pc_inc, pc_load, pc_out
    );

    modport slave (
        output instr, flag_c, flag_z,
        input  step, hlt, mar_in, ram_in, ram_out, ir_in, ir_out,
               a_in, a_out, b_in, alu_out, alu_sub, flags_in, out_in,
               pc_inc, pc_load, pc_out
    );
endinterface

// File: rtl/control_sequencer.sv
// Microcoded control unit for the 8-bit bus computer.
// A T-state step counter runs the fetch (T0-T1) and the execute steps (T2-T4).
// Bus strobes are decoded combinationally from the step, the opcode
// (instr[7:4]), the flags and the halted flag.
// Optional feature: when the macro CU_EARLY_END_EN is defined, each
// instruction wraps to T0 right after its last step that has a strobe.
// When the macro is undefined, every instruction runs T0..LAST_STEP.
//
// mode    | meaning
// --------+-----------------------------------------------------------
// RUN     | step counter advances each clock and strobes follow decode
// HALTED  | step is frozen at T2, only hlt is high, only rst leaves it
module control_sequencer #(
    parameter int STEP_W    = 3,
    parameter int LAST_STEP = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    control_sequencer_if.master  bus
);

    typedef enum logic {
        RUN    = 1'b0,
        HALTED = 1'b1
    } mode_t;

    localparam logic [STEP_W-1:0] T0   = STEP_W'(0);
    localparam logic [STEP_W-1:0] T1   = STEP_W'(1);
    localparam logic [STEP_W-1:0] T2   = STEP_W'(2);
    localparam logic [STEP_W-1:0] T3   = STEP_W'(3);
    localparam logic [STEP_W-1:0] T4   = STEP_W'(4);
    localparam logic [STEP_W-1:0] LAST = STEP_W'(LAST_STEP);

    localparam logic [3:0] OP_NOP = 4'h0;
    localparam logic [3:0] OP_LDA = 4'h1;
    localparam logic [3:0] OP_ADD = 4'h2;
    localparam logic [3:0] OP_SUB = 4'h3;
    localparam logic [3:0] OP_STA = 4'h4;
    localparam logic [3:0] OP_LDI = 4'h5;
    localparam logic [3:0] OP_JMP = 4'h6;
    localparam logic [3:0] OP_JC  = 4'h7;
    localparam logic [3:0] OP_JZ  = 4'h8;
    localparam logic [3:0] OP_OUT = 4'hE;
    localparam logic [3:0] OP_HLT = 4'hF;

    mode_t             mode_q, mode_d;
    logic [STEP_W-1:0] step_q, step_d;
    logic [STEP_W-1:0] end_step;
    logic [3:0]        opcode;

    logic hlt_c, mar_in_c, ram_in_c, ram_out_c, ir_in_c, ir_out_c;
    logic a_in_c, a_out_c, b_in_c, alu_out_c, alu_sub_c, flags_in_c;
    logic out_in_c, pc_inc_c, pc_load_c, pc_out_c;

    // The low nibble of IR is an operand. The IR itself puts it on the bus,
    // so the sequencer never looks at it.
    logic unused_instr_lo;
    assign unused_instr_lo = ^bus.instr[3:0];

    assign opcode = bus.instr[7:4];

    // State register: step counter and halt mode, async reset to T0 / RUN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            step_q <= T0;
            mode_q <= RUN;
        end else begin
            step_q <= step_d;
            mode_q <= mode_d;
        end
    end

    // Microcode decode and next-step computation
    always_comb begin
        hlt_c      = 1'b0;
        mar_in_c   = 1'b0;
        ram_in_c   = 1'b0;
        ram_out_c  = 1'b0;
        ir_in_c    = 1'b0;
        ir_out_c   = 1'b0;
        a_in_c     = 1'b0;
        a_out_c    = 1'b0;
        b_in_c     = 1'b0;
        alu_out_c  = 1'b0;
        alu_sub_c  = 1'b0;
        flags_in_c = 1'b0;
        out_in_c   = 1'b0;
        pc_inc_c   = 1'b0;
        pc_load_c  = 1'b0;
        pc_out_c   = 1'b0;
        step_d     = step_q;
        mode_d     = mode_q;
        end_step   = LAST;

`ifdef CU_EARLY_END_EN
        case (opcode)
            OP_LDA, OP_STA:                         end_step = T3;
            OP_ADD, OP_SUB:                         end_step = T4;
            OP_LDI, OP_JMP, OP_JC, OP_JZ, OP_OUT,
            OP_HLT:                                 end_step = T2;
            default:                                end_step = T1;
        endcase
`endif

        if (mode_q == HALTED) begin
            hlt_c = 1'b1;
        end else begin
            case (step_q)
                T0: begin
                    pc_out_c = 1'b1;
                    mar_in_c = 1'b1;
                end
                T1: begin
                    ram_out_c = 1'b1;
                    ir_in_c   = 1'b1;
                    pc_inc_c  = 1'b1;
                end
                T2: begin
                    case (opcode)
                        OP_LDA, OP_ADD, OP_SUB, OP_STA: begin
                            ir_out_c = 1'b1;
                            mar_in_c = 1'b1;
                        end
                        OP_LDI: begin
                            ir_out_c = 1'b1;
                            a_in_c   = 1'b1;
                        end
                        OP_JMP: begin
                            ir_out_c  = 1'b1;
                            pc_load_c = 1'b1;
                        end
                        OP_JC: begin
                            ir_out_c  = bus.flag_c;
                            pc_load_c = bus.flag_c;
                        end
                        OP_JZ: begin
                            ir_out_c  = bus.flag_z;
                            pc_load_c = bus.flag_z;
                        end
                        OP_OUT: begin
                            a_out_c  = 1'b1;
                            out_in_c = 1'b1;
                        end
                        OP_HLT: hlt_c = 1'b1;
                        default: ;
                    endcase
                end
                T3: begin
                    case (opcode)
                        OP_LDA: begin
                            ram_out_c = 1'b1;
                            a_in_c    = 1'b1;
                        end
                        OP_ADD, OP_SUB: begin
                            ram_out_c = 1'b1;
                            b_in_c    = 1'b1;
                        end
                        OP_STA: begin
                            a_out_c  = 1'b1;
                            ram_in_c = 1'b1;
                        end
                        default: ;
                    endcase
                end
                T4: begin
                    if (opcode == OP_ADD || opcode == OP_SUB) begin
                        alu_out_c  = 1'b1;
                        a_in_c     = 1'b1;
                        flags_in_c = 1'b1;
                        alu_sub_c  = (opcode == OP_SUB);
                    end
                end
                default: ;
            endcase

            // HLT holds the counter at T2. Every other opcode advances or wraps.
            if (opcode == OP_HLT && step_q == T2) begin
                mode_d = HALTED;
            end else if (step_q == end_step) begin
                step_d = T0;
            end else begin
                step_d = step_q + 1'b1;
            end
        end
    end

    // While reset is asserted, no strobe may leak from the T0 decode
    assign bus.step     = step_q;
    assign bus.hlt      = hlt_c      & ~rst;
    assign bus.mar_in   = mar_in_c   & ~rst;
    assign bus.ram_in   = ram_in_c   & ~rst;
    assign bus.ram_out  = ram_out_c  & ~rst;
    assign bus.ir_in    = ir_in_c    & ~rst;
    assign bus.ir_out   = ir_out_c   & ~rst;
    assign bus.a_in     = a_in_c     & ~rst;
    assign bus.a_out    = a_out_c    & ~rst;
    assign bus.b_in     = b_in_c     & ~rst;
    assign bus.alu_out  = alu_out_c  & ~rst;
    assign bus.alu_sub  = alu_sub_c  & ~rst;
    assign bus.flags_in = flags_in_c & ~rst;
    assign bus.out_in   = out_in_c   & ~rst;
    assign bus.pc_inc   = pc_inc_c   & ~rst;
    assign bus.pc_load  = pc_load_c  & ~rst;
    assign bus.pc_out   = pc_out_c   & ~rst;

endmodule
